miss_msg_det_mc: RTL and testbench

MISS_MSG_DET_MC -- requirements
Module: miss_msg_det_mc

---
 rtl/miss_msg_pkg.sv | 22 ++
 rtl/gap_fifo.sv | 48 ++++
 rtl/miss_msg_det_mc.sv | 131 +++++++++++++
 tb/tb_miss_msg_det_mc.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miss_msg_pkg.sv
// Shared widths and gap record layout for the missed-message detector.
package miss_msg_pkg;

    localparam int unsigned CH_N_DEF       = 2;
    localparam int unsigned CH_W_DEF       = 1;
    localparam int unsigned SEQ_NUM_W_DEF  = 64;
    localparam int unsigned SID_W_DEF      = 80;
    localparam int unsigned ML_W_DEF       = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // Field order matches the packed vector stored in the gap queue.
    typedef struct packed {
        logic [CH_W_DEF-1:0]      ch;
        logic [SID_W_DEF-1:0]     sid;
        logic [SEQ_NUM_W_DEF-1:0] start;
        logic [SEQ_NUM_W_DEF-1:0] cnt;
        logic                     sid_chg;
    } gap_rec_t;

    localparam int unsigned GAP_REC_W = $bits(gap_rec_t);

endpackage

// File: rtl/gap_fifo.sv
// Power-of-two FIFO with simultaneous push/pop; head reads as zero when empty.
module gap_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/miss_msg_det_mc.sv
// Per-channel sequence tracker that queues gap records for missed messages.
module miss_msg_det_mc
    import miss_msg_pkg::*;
#(
    parameter int unsigned CH_N       = CH_N_DEF,
    parameter int unsigned CH_W       = $clog2(CH_N),
    parameter int unsigned SEQ_NUM_W  = SEQ_NUM_W_DEF,
    parameter int unsigned SID_W      = SID_W_DEF,
    parameter int unsigned ML_W       = ML_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 v_i,
    input  logic [CH_W-1:0]      ch_i,
    input  logic [SID_W-1:0]     sid_i,
    input  logic [SEQ_NUM_W-1:0] seq_num_i,
    input  logic [ML_W-1:0]      msg_cnt_i,
    input  logic                 eos_i,
    output logic                 gap_v_o,
    input  logic                 gap_ready_i,
    output logic [CH_W-1:0]      gap_ch_o,
    output logic [SID_W-1:0]     gap_sid_o,
    output logic [SEQ_NUM_W-1:0] gap_seq_start_o,
    output logic [SEQ_NUM_W-1:0] gap_cnt_o,
    output logic                 gap_sid_chg_o,
    output logic                 dup_o,
    output logic                 ovf_o
);

    localparam int unsigned REC_W = CH_W + SID_W + 2 * SEQ_NUM_W + 1;

    logic                 sync_q [CH_N];
    logic [SID_W-1:0]     sid_q  [CH_N];
    logic [SEQ_NUM_W-1:0] seq_q  [CH_N];

    logic [SID_W-1:0]     cur_sid;
    logic [SEQ_NUM_W-1:0] cur_seq;
    logic [SEQ_NUM_W-1:0] end_seq;
    logic [SID_W-1:0]     nxt_sid;
    logic [SEQ_NUM_W-1:0] nxt_seq;
    logic                 push_c;
    logic                 dup_c;
    logic [REC_W-1:0]     rec_c;
    logic [REC_W-1:0]     head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_c;

    assign cur_sid = sid_q[ch_i];
    assign cur_seq = seq_q[ch_i];
    assign end_seq = seq_num_i + SEQ_NUM_W'(msg_cnt_i);

    // Gap classification of the incoming header against its channel state.
    always_comb begin
        nxt_sid = cur_sid;
        nxt_seq = cur_seq;
        push_c  = 1'b0;
        dup_c   = 1'b0;
        rec_c   = '0;
        if (!sync_q[ch_i]) begin
            nxt_sid = sid_i;
            nxt_seq = end_seq;
        end else if (sid_i != cur_sid) begin
            nxt_sid = sid_i;
            nxt_seq = end_seq;
            if (seq_num_i != '0) begin
                push_c = v_i;
                rec_c  = {ch_i, sid_i, SEQ_NUM_W'(0), seq_num_i, 1'b1};
            end
        end else if (seq_num_i == cur_seq) begin
            nxt_seq = end_seq;
        end else if (seq_num_i > cur_seq) begin
            push_c  = v_i;
            rec_c   = {ch_i, cur_sid, cur_seq, seq_num_i - cur_seq, 1'b0};
            nxt_seq = end_seq;
        end else if (end_seq > cur_seq) begin
            nxt_seq = end_seq;
        end else begin
            dup_c = v_i;
        end
        if (eos_i) begin
            nxt_sid = nxt_sid + SID_W'(1);
            nxt_seq = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < int'(CH_N); i++) begin
                sync_q[i] <= 1'b0;
                sid_q[i]  <= '0;
                seq_q[i]  <= '0;
            end
        end else if (v_i) begin
            sync_q[ch_i] <= 1'b1;
            sid_q[ch_i]  <= nxt_sid;
            seq_q[ch_i]  <= nxt_seq;
        end
    end

    assign pop_c = gap_v_o && gap_ready_i;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            dup_o <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            dup_o <= dup_c;
            if (push_c && fifo_full && !pop_c) ovf_o <= 1'b1;
        end
    end

    gap_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_gap_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push_c),
        .din    (rec_c),
        .pop    (pop_c),
        .dout   (head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign gap_v_o = !fifo_empty;
    assign {gap_ch_o, gap_sid_o, gap_seq_start_o, gap_cnt_o, gap_sid_chg_o} = head;

endmodule

// File: tb/tb_miss_msg_det_mc.sv
// Randomized and directed bench for miss_msg_det_mc against a queue-based model.
module tb_miss_msg_det_mc;
    import miss_msg_pkg::*;

    localparam int CH_N  = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nreset;
    logic        v_i;
    logic [0:0]  ch_i;
    logic [79:0] sid_i;
    logic [63:0] seq_num_i;
    logic [15:0] msg_cnt_i;
    logic        eos_i;
    logic        gap_v_o;
    logic        gap_ready_i;
    logic [0:0]  gap_ch_o;
    logic [79:0] gap_sid_o;
    logic [63:0] gap_seq_start_o;
    logic [63:0] gap_cnt_o;
    logic        gap_sid_chg_o;
    logic        dup_o;
    logic        ovf_o;

    always #5 clk = ~clk;

    miss_msg_det_mc dut (
        .clk             (clk),
        .nreset          (nreset),
        .v_i             (v_i),
        .ch_i            (ch_i),
        .sid_i           (sid_i),
        .seq_num_i       (seq_num_i),
        .msg_cnt_i       (msg_cnt_i),
        .eos_i           (eos_i),
        .gap_v_o         (gap_v_o),
        .gap_ready_i     (gap_ready_i),
        .gap_ch_o        (gap_ch_o),
        .gap_sid_o       (gap_sid_o),
        .gap_seq_start_o (gap_seq_start_o),
        .gap_cnt_o       (gap_cnt_o),
        .gap_sid_chg_o   (gap_sid_chg_o),
        .dup_o           (dup_o),
        .ovf_o           (ovf_o)
    );

    int n_vec = 0;
    int n_err = 0;

    bit          m_sync [CH_N];
    logic [79:0] m_sid  [CH_N];
    logic [63:0] m_seq  [CH_N];
    gap_rec_t    mq[$];
    bit          m_dup;
    bit          m_ovf;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what the design state should be after the coming clock edge.
    task automatic model_step();
        gap_rec_t    r;
        bit          has_rec;
        int          c;
        logic [63:0] last;
        if (!nreset) begin
            for (int i = 0; i < CH_N; i++) begin
                m_sync[i] = 0; m_sid[i] = '0; m_seq[i] = '0;
            end
            mq.delete();
            m_dup = 0;
            m_ovf = 0;
            return;
        end
        m_dup = 0;
        if (gap_ready_i && mq.size() > 0) void'(mq.pop_front());
        if (!v_i) return;
        c       = int'(ch_i);
        last    = seq_num_i + {48'd0, msg_cnt_i};
        has_rec = 0;
        r       = '0;
        r.ch    = ch_i;
        if (!m_sync[c] || sid_i != m_sid[c]) begin
            if (m_sync[c] && seq_num_i != 0) begin
                has_rec = 1; r.sid = sid_i; r.start = 0; r.cnt = seq_num_i; r.sid_chg = 1;
            end
            m_sid[c] = sid_i;
            m_seq[c] = last;
        end else if (seq_num_i >= m_seq[c]) begin
            if (seq_num_i != m_seq[c]) begin
                has_rec = 1; r.sid = m_sid[c]; r.start = m_seq[c];
                r.cnt = seq_num_i - m_seq[c]; r.sid_chg = 0;
            end
            m_seq[c] = last;
        end else if (last > m_seq[c]) begin
            m_seq[c] = last;
        end else begin
            m_dup = 1;
        end
        m_sync[c] = 1;
        if (eos_i) begin
            m_sid[c] = m_sid[c] + 80'd1;
            m_seq[c] = 0;
        end
        if (has_rec) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else m_ovf = 1;
        end
    endtask

    task automatic check_outputs();
        check("gap_v", 256'(gap_v_o), 256'(mq.size() > 0));
        if (mq.size() > 0)
            check("gap_rec", 256'({gap_ch_o, gap_sid_o, gap_seq_start_o, gap_cnt_o, gap_sid_chg_o}),
                  256'(mq[0]));
        check("dup", 256'(dup_o), 256'(m_dup));
        check("ovf", 256'(ovf_o), 256'(m_ovf));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input int ch, input int sid, input longint seq, input int cnt, input bit eos);
        v_i = 1'b1; ch_i = 1'(ch); sid_i = 80'(sid); seq_num_i = 64'(seq);
        msg_cnt_i = 16'(cnt); eos_i = eos;
        cycle();
        v_i = 1'b0; eos_i = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0; v_i = 1'b1; ch_i = 1'b0; sid_i = 80'd3; seq_num_i = 64'd9;
        cycle();
        v_i = 1'b0;
        check("rst_fields", 256'({gap_ch_o, gap_sid_o, gap_seq_start_o, gap_cnt_o, gap_sid_chg_o}), 256'(0));
        nreset = 1'b1;
    endtask

    initial begin
        int          mode;
        logic [63:0] base;
        nreset = 1'b0; v_i = 1'b0; ch_i = '0; sid_i = '0; seq_num_i = '0;
        msg_cnt_i = '0; eos_i = 1'b0; gap_ready_i = 1'b1;
        @(negedge clk);
        do_reset();
        do_reset();

        send(0, 5, 0, 3, 0);
        send(0, 5, 3, 2, 0);
        check("r20_nogap", 256'(gap_v_o), 256'(0));
        send(0, 5, 5, 1, 0);
        check("r20_seq5", 256'(gap_v_o), 256'(0));

        send(1, 9, 0, 10, 0);
        send(1, 9, 17, 1, 0);
        check("r21_v", 256'(gap_v_o), 256'(1));
        check("r21_ch", 256'(gap_ch_o), 256'(1));
        check("r21_start", 256'(gap_seq_start_o), 256'(10));
        check("r21_cnt", 256'(gap_cnt_o), 256'(7));
        check("r21_chg", 256'(gap_sid_chg_o), 256'(0));
        send(1, 9, 18, 1, 0);
        check("r21_seq18", 256'(gap_v_o), 256'(0));

        send(0, 5, 6, 14, 0);
        send(0, 5, 15, 3, 0);
        check("r22_dup", 256'(dup_o), 256'(1));
        send(0, 5, 18, 4, 0);
        check("r22_dup_once", 256'(dup_o), 256'(0));
        check("r22_overlap", 256'(gap_v_o), 256'(0));
        send(0, 5, 22, 1, 0);
        check("r22_seq22", 256'(gap_v_o), 256'(0));

        send(0, 7, 4, 2, 0);
        check("r23_sid", 256'(gap_sid_o), 256'(7));
        check("r23_start", 256'(gap_seq_start_o), 256'(0));
        check("r23_cnt", 256'(gap_cnt_o), 256'(4));
        check("r23_chg", 256'(gap_sid_chg_o), 256'(1));
        send(0, 7, 6, 1, 1);
        send(0, 8, 0, 1, 0);
        check("r23_eos", 256'(gap_v_o), 256'(0));

        gap_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) send(1, 9, 20 + 2 * k, 1, 0);
        check("r24_ovf", 256'(ovf_o), 256'(1));
        gap_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("r24_drain", 256'(gap_seq_start_o), 256'(19 + 2 * k));
            cycle();
        end
        check("r24_empty", 256'(gap_v_o), 256'(0));

        gap_ready_i = 1'b0;
        send(1, 9, 31, 1, 0);
        send(1, 9, 33, 1, 0);
        check("r25_queued", 256'(gap_v_o), 256'(1));
        do_reset();
        check("r25_v", 256'(gap_v_o), 256'(0));
        check("r25_ovf", 256'(ovf_o), 256'(0));
        send(1, 9, 100, 1, 0);
        send(1, 9, 101, 1, 0);
        check("r25_first", 256'(gap_v_o), 256'(0));

        for (int n = 0; n < 3000; n++) begin
            gap_ready_i = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                continue;
            end
            v_i       = ($urandom_range(0, 4) != 0);
            ch_i      = 1'($urandom_range(0, 1));
            base      = m_seq[int'(ch_i)];
            sid_i     = ($urandom_range(0, 9) == 0) ? 80'($urandom_range(0, 3)) : m_sid[int'(ch_i)];
            msg_cnt_i = 16'($urandom_range(0, 5));
            eos_i     = ($urandom_range(0, 15) == 0);
            mode      = int'($urandom_range(0, 6));
            case (mode)
                0, 1: seq_num_i = base;
                2:    seq_num_i = base + 64'($urandom_range(1, 4));
                3:    begin seq_num_i = base - 64'($urandom_range(1, 3)); msg_cnt_i = 16'($urandom_range(2, 8)); end
                4:    seq_num_i = base - 64'($urandom_range(2, 6));
                5:    seq_num_i = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
                default: seq_num_i = 64'($urandom_range(0, 6));
            endcase
            cycle();
        end
        v_i = 1'b0;
        gap_ready_i = 1'b1;
        for (int n = 0; n < 8; n++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
